// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and processing mode encodings for the I2S loopback core
package audio_pkg;
    localparam int SLOT_BITS = 32;
    localparam int WL_MIN    = 8;
    localparam int WL_MAX    = 32;
    localparam int CH_MIN    = 2;
    localparam int CH_MAX    = 8;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_SWAP = 2'b01,
        MODE_MIX  = 2'b10,
        MODE_MUTE = 2'b11
    } mode_e;
endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - BCLK/LRC divider with rise/fall/frame strobes and bit position
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int  CH       = 2,
    parameter int  BCLK_DIV = 4,
    localparam int BC_W     = $clog2(CH * SLOT_BITS),
    localparam int B_W      = $clog2(SLOT_BITS),
    localparam int SLOT_W   = BC_W - B_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              bclk,
    output logic              lrc,
    output logic              rise,
    output logic              fall,
    output logic              frame,
    output logic [SLOT_W-1:0] slot,
    output logic [B_W-1:0]    b
);
    localparam int CNT_W = $clog2(BCLK_DIV + 1);

    logic             run;
    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic [BC_W-1:0]  bc;
    logic [BC_W-1:0]  bc_nxt;
    logic [BC_W-1:0]  pos;

    assign tick   = run && (cnt == CNT_W'(BCLK_DIV - 1));
    assign rise   = tick && !bclk;
    assign fall   = tick && bclk;
    assign frame  = fall && (bc == BC_W'(CH * SLOT_BITS - 1));
    assign bc_nxt = frame ? '0 : bc + BC_W'(1);

    // On a fall event the position refers to the bit about to be launched
    assign pos  = fall ? bc_nxt : bc;
    assign slot = pos[BC_W-1:B_W];
    assign b    = pos[B_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run  <= 1'b0;
            cnt  <= '0;
            bc   <= '0;
            bclk <= 1'b0;
            lrc  <= 1'b0;
        end else if (!run) begin
            if (en) run <= 1'b1;
        end else begin
            if (tick) begin
                cnt  <= '0;
                bclk <= ~bclk;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (fall) begin
                bc  <= bc_nxt;
                lrc <= (bc_nxt >= BC_W'(CH * SLOT_BITS / 2));
            end
            if (frame && !en) run <= 1'b0;
        end
    end
endmodule

// File: rtl/i2s_loopback_core.sv
// rtl/i2s_loopback_core.sv - I2S/TDM master loopback: capture, per-frame processing, replay
module i2s_loopback_core
    import audio_pkg::*;
#(
    parameter int WL       = 24,
    parameter int CH       = 2,
    parameter int BCLK_DIV = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [2:0]       atten,
    input  logic             aud_adcdat,
    output logic             aud_bclk,
    output logic             aud_lrc,
    output logic             aud_dacdat,
    output logic [CH*WL-1:0] rx_data,
    output logic             rx_valid
);
    localparam int BC_W   = $clog2(CH * SLOT_BITS);
    localparam int B_W    = $clog2(SLOT_BITS);
    localparam int SLOT_W = BC_W - B_W;
    localparam int IDX_W  = $clog2(WL);
    localparam logic [B_W:0] WL_L = WL[B_W:0];

    logic              rise;
    logic              fall;
    logic              frame;
    logic [SLOT_W-1:0] slot;
    logic [B_W-1:0]    b;
    logic              in_word;
    logic [IDX_W-1:0]  tx_idx;

    logic [WL-1:0] rx_sh [CH];
    logic [WL-1:0] tx    [CH];
    logic [WL-1:0] pre   [CH];
    logic [WL-1:0] proc  [CH];

    i2s_clk_gen #(
        .CH       (CH),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bclk  (aud_bclk),
        .lrc   (aud_lrc),
        .rise  (rise),
        .fall  (fall),
        .frame (frame),
        .slot  (slot),
        .b     (b)
    );

    // Bit 0 of each slot is the I2S one-bit delay; bits past WL are padding
    assign in_word = (b != '0) && ({1'b0, b} <= WL_L);
    assign tx_idx  = IDX_W'(WL_L - {1'b0, b});

    always_comb begin
        logic [WL:0] sum;
        for (int s = 0; s < CH; s++) begin
            pre[s] = '0;
        end
        for (int p = 0; p < CH / 2; p++) begin
            // One extra bit keeps the pair sum from wrapping before the halving
            sum = {rx_sh[2*p][WL-1], rx_sh[2*p]} + {rx_sh[2*p+1][WL-1], rx_sh[2*p+1]};
            case (mode)
                MODE_PASS: begin
                    pre[2*p]   = rx_sh[2*p];
                    pre[2*p+1] = rx_sh[2*p+1];
                end
                MODE_SWAP: begin
                    pre[2*p]   = rx_sh[2*p+1];
                    pre[2*p+1] = rx_sh[2*p];
                end
                MODE_MIX: begin
                    pre[2*p]   = sum[WL:1];
                    pre[2*p+1] = sum[WL:1];
                end
                default: begin
                    pre[2*p]   = '0;
                    pre[2*p+1] = '0;
                end
            endcase
        end
        for (int s = 0; s < CH; s++) begin
            proc[s] = $signed(pre[s]) >>> atten;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < CH; s++) begin
                rx_sh[s] <= '0;
                tx[s]    <= '0;
            end
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            aud_dacdat <= 1'b0;
        end else begin
            rx_valid <= frame && en;
            if (rise && in_word) rx_sh[slot] <= {rx_sh[slot][WL-2:0], aud_adcdat};
            if (fall) aud_dacdat <= in_word ? tx[slot][tx_idx] : 1'b0;
            if (frame) begin
                for (int s = 0; s < CH; s++) begin
                    if (en) rx_data[s*WL +: WL] <= rx_sh[s];
                    // A stopping core restarts from silence rather than a stale frame
                    tx[s] <= en ? proc[s] : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_loopback_core.sv
// tb/tb_i2s_loopback_core.sv - scoreboard bench for i2s_loopback_core with an ADC BFM and DAC monitor
`timescale 1ns/1ps
module tb_i2s_loopback_core;
    localparam int WL       = 24;
    localparam int CH       = 2;
    localparam int BCLK_DIV = 4;
    localparam int FBITS    = CH * 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [2:0]       atten = 3'd0;
    logic             aud_adcdat = 1'b0;
    logic             aud_bclk;
    logic             aud_lrc;
    logic             aud_dacdat;
    logic [CH*WL-1:0] rx_data;
    logic             rx_valid;

    i2s_loopback_core #(.WL(WL), .CH(CH), .BCLK_DIV(BCLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .atten      (atten),
        .aud_adcdat (aud_adcdat),
        .aud_bclk   (aud_bclk),
        .aud_lrc    (aud_lrc),
        .aud_dacdat (aud_dacdat),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [1:0]  md;
        logic [2:0]  at;
        logic [2:0]  at_mid;
        bit          chg;
        bit          stop;
        int          rst_at;
    } frame_t;

    int          errs = 0;
    int          checks = 0;
    logic [47:0] rxq [$];
    logic [47:0] dacq [$];
    int          rise_cnt = 0;
    int          frame_err = 0;
    logic [23:0] dac_w [2];
    int          mp, ms, mb;
    logic [47:0] mexp;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sx(input logic [23:0] v);
        return v[23] ? int'(v) - (1 << 24) : int'(v);
    endfunction

    function automatic int floor_div(input int x, input int d);
        return (x >= 0) ? x / d : -((-x + d - 1) / d);
    endfunction

    // Reference: slot values as signed integers, mix is the floor of the mean,
    // attenuation is floor division by a power of two
    function automatic logic [47:0] model(input logic [23:0] l, input logic [23:0] r,
                                          input logic [1:0] md, input logic [2:0] at);
        int a = sx(l);
        int c = sx(r);
        int oa;
        int ob;
        case (md)
            2'd0:    begin oa = a; ob = c; end
            2'd1:    begin oa = c; ob = a; end
            2'd2:    begin oa = floor_div(a + c, 2); ob = oa; end
            default: begin oa = 0; ob = 0; end
        endcase
        oa = floor_div(oa, 1 << at);
        ob = floor_div(ob, 1 << at);
        return {ob[23:0], oa[23:0]};
    endfunction

    function automatic frame_t mk(input logic [23:0] l, input logic [23:0] r,
                                  input logic [1:0] md, input logic [2:0] at);
        frame_t f;
        f.l = l; f.r = r; f.md = md; f.at = at;
        f.at_mid = at; f.chg = 1'b0; f.stop = 1'b0; f.rst_at = -1;
        return f;
    endfunction

    function automatic frame_t mk_rand();
        frame_t f;
        f = mk(24'($urandom), 24'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        f.chg = 1'($urandom);
        f.at_mid = 3'($urandom_range(0, 7));
        return f;
    endfunction

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            check("rx_expected_available", 48'(rxq.size() > 0), 48'd1);
            if (rxq.size() > 0) check("rx_data", rx_data, rxq.pop_front());
        end
    end

    // Codec side of the DAC link: sample on each BCLK rise
    always @(posedge aud_bclk) begin
        #1;
        mp = rise_cnt % FBITS;
        ms = mp / 32;
        mb = mp % 32;
        if (aud_lrc !== 1'(mp >= FBITS / 2)) frame_err++;
        if (mb >= 1 && mb <= WL) dac_w[ms] = {dac_w[ms][22:0], aud_dacdat};
        else if (aud_dacdat !== 1'b0) frame_err++;
        rise_cnt++;
        if (mp == FBITS - 1) begin
            check("dac_expected_available", 48'(dacq.size() > 0), 48'd1);
            if (dacq.size() > 0) begin
                mexp = dacq.pop_front();
                check("dac_left", 48'(dac_w[0]), 48'(mexp[23:0]));
                check("dac_right", 48'(dac_w[1]), 48'(mexp[47:24]));
            end
            check("dac_framing", 48'(frame_err), 48'd0);
            frame_err = 0;
        end
    end

    task automatic wait_fall(output bit ok);
        logic prev;
        prev = aud_bclk;
        ok = 1'b0;
        for (int n = 0; n < 4 * BCLK_DIV + 4 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (prev === 1'b1 && aud_bclk === 1'b0) ok = 1'b1;
            prev = aud_bclk;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_bclk", 48'(aud_bclk), 48'd0);
        check("rst_lrc", 48'(aud_lrc), 48'd0);
        check("rst_dacdat", 48'(aud_dacdat), 48'd0);
        check("rst_rx_valid", 48'(rx_valid), 48'd0);
        check("rst_rx_data", rx_data, 48'd0);
        rxq.delete();
        dacq.delete();
        rise_cnt = 0;
        frame_err = 0;
        dacq.push_back(48'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input frame_t f, output bit ok);
        logic [47:0] w;
        int pos;
        int s;
        int bb;
        w = {f.r, f.l};
        ok = 1'b1;
        mode = f.md;
        atten = f.at;
        if (!f.stop && f.rst_at < 0) begin
            rxq.push_back(w);
            dacq.push_back(model(f.l, f.r, f.md, f.chg ? f.at_mid : f.at));
        end
        for (int i = 1; i <= FBITS; i++) begin
            wait_fall(ok);
            if (!ok) begin
                check("bclk_fall_timeout", 48'd0, 48'd1);
                return;
            end
            pos = i % FBITS;
            s = pos / 32;
            bb = pos % 32;
            if (pos == 10 && f.stop) en = 1'b0;
            if (pos == 20 && f.chg) atten = f.at_mid;
            if (pos == f.rst_at) begin
                do_reset();
                return;
            end
            aud_adcdat = (bb >= 1 && bb <= WL) ? w[s*24 + WL - bb] : 1'($urandom);
        end
    endtask

    task automatic idle_check(input string name);
        int idle_err = 0;
        repeat (600) begin
            @(negedge clk);
            if ((aud_bclk | aud_lrc | aud_dacdat) !== 1'b0) idle_err++;
        end
        check(name, 48'(idle_err), 48'd0);
    endtask

    initial begin
        frame_t plan [$];
        frame_t f;
        bit ok;

        ok = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bclk", 48'(aud_bclk), 48'd0);
        check("reset_lrc", 48'(aud_lrc), 48'd0);
        check("reset_dacdat", 48'(aud_dacdat), 48'd0);
        check("reset_rx_valid", 48'(rx_valid), 48'd0);
        check("reset_rx_data", rx_data, 48'd0);
        rst_n = 1'b1;
        idle_check("idle_before_enable");

        plan.push_back(mk(24'h123456, 24'hABCDEF, 2'd0, 3'd0));
        plan.push_back(mk(24'h000001, 24'h800000, 2'd1, 3'd0));
        plan.push_back(mk(24'h7FFFFF, 24'h7FFFFF, 2'd2, 3'd0));
        plan.push_back(mk(24'h800000, 24'h000000, 2'd2, 3'd0));
        plan.push_back(mk(24'hFFFF80, 24'h000400, 2'd0, 3'd3));
        f = mk(24'h654321, 24'hF00F00, 2'd0, 3'd3);
        f.chg = 1'b1;
        f.at_mid = 3'd0;
        plan.push_back(f);
        f = mk_rand();
        f.stop = 1'b1;
        plan.push_back(f);
        for (int i = 0; i < 8; i++) plan.push_back(mk_rand());
        f = mk_rand();
        f.rst_at = 40;
        plan.push_back(f);
        for (int i = 0; i < 4; i++) plan.push_back(mk_rand());
        f = mk_rand();
        f.stop = 1'b1;
        plan.push_back(f);

        dacq.push_back(48'd0);
        en = 1'b1;
        foreach (plan[k]) begin
            if (ok) begin
                run_frame(plan[k], ok);
                if (ok && plan[k].stop) begin
                    idle_check("idle_after_stop");
                    if (k != plan.size() - 1) begin
                        dacq.push_back(48'd0);
                        en = 1'b1;
                    end
                end
            end
        end

        check("rx_queue_drained", 48'(rxq.size()), 48'd0);
        check("dac_queue_drained", 48'(dacq.size()), 48'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
